gf180mcu_fd_sc_mcu7t5v0__oai211_bist: RTL and testbench



---
 rtl/gf180mcu_fd_sc_mcu7t5v0__bist_pkg.sv | 25 ++
 rtl/gf180mcu_fd_sc_mcu7t5v0__bist_settle_cnt.sv | 36 +++
 rtl/gf180mcu_fd_sc_mcu7t5v0__oai211_bist.sv | 166 ++++++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu7t5v0__oai211_bist.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__bist_pkg.sv
// Shared types and helpers for the aoi/oai standard-cell BIST sequencers.
package gf180mcu_fd_sc_mcu7t5v0__bist_pkg;

  localparam int unsigned ERR_CNT_W = 5;
  localparam int unsigned SETTLE_W  = 4;
  localparam int unsigned PASS_W    = 2;

  typedef enum logic [2:0] {
    StIdle,
    StApply,
    StSettle,
    StCheck,
    StFinish
  } bist_state_e;

  function automatic logic [3:0] gray4(input logic [3:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Vector is packed {A1, A2, B, C}.
  function automatic logic oai211_exp(input logic [3:0] vec);
    return ~((vec[3] | vec[2]) & vec[1] & vec[0]);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__bist_settle_cnt.sv
// Loadable down-counter with a zero flag; holds the current vector before sampling.
module gf180mcu_fd_sc_mcu7t5v0__bist_settle_cnt
  import gf180mcu_fd_sc_mcu7t5v0__bist_pkg::*;
#(
  parameter int unsigned Width = SETTLE_W
) (
  input  logic             clk_i,
  input  logic             rn_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__oai211_bist.sv
// BIST sequencer for an oai211 cell: walks 16 Gray-ordered vectors, checks ZN, logs errors.
module gf180mcu_fd_sc_mcu7t5v0__oai211_bist
  import gf180mcu_fd_sc_mcu7t5v0__bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned PASSES        = 1
) (
  input  logic                 clk_i,
  input  logic                 rn_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 zn_i,
  output logic                 a1_o,
  output logic                 a2_o,
  output logic                 b_o,
  output logic                 c_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic [3:0]           fail_vec_o
);

  localparam logic [SETTLE_W-1:0] SettleLoad = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [PASS_W-1:0]   LastPass   = PASS_W'(PASSES - 1);

  bist_state_e          state_q, state_d;
  logic [3:0]           step_q, step_d;
  logic [PASS_W-1:0]    pass_cnt_q, pass_cnt_d;
  logic [3:0]           vec_q, vec_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic [3:0]           fail_q, fail_d;
  logic                 pass_q, pass_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 cnt_load, cnt_dec, cnt_zero, aborted;

  gf180mcu_fd_sc_mcu7t5v0__bist_settle_cnt #(
    .Width(SETTLE_W)
  ) u_settle_cnt (
    .clk_i     (clk_i),
    .rn_i      (rn_i),
    .load_i    (cnt_load),
    .load_val_i(SettleLoad),
    .dec_i     (cnt_dec),
    .zero_o    (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    pass_cnt_d = pass_cnt_q;
    err_d      = err_q;
    fail_d     = fail_q;
    pass_d     = pass_q;
    done_d     = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    aborted    = 1'b0;

    // Abort outranks everything, including the comparison pending in CHECK.
    if (abort_i && (state_q inside {StApply, StSettle, StCheck})) begin
      state_d = StFinish;
      aborted = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            err_d      = '0;
            fail_d     = '0;
            pass_d     = 1'b0;
            step_d     = '0;
            pass_cnt_d = '0;
            state_d    = StApply;
          end
        end
        StApply: begin
          cnt_load = 1'b1;
          state_d  = StSettle;
        end
        StSettle: begin
          if (cnt_zero) begin
            state_d = StCheck;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        StCheck: begin
          if (zn_i != oai211_exp(vec_q)) begin
            if (err_q == '0) begin
              fail_d = vec_q;
            end
            if (err_q != '1) begin
              err_d = err_q + 1'b1;
            end
          end
          if (step_q == 4'hf) begin
            if (pass_cnt_q == LastPass) begin
              state_d = StFinish;
            end else begin
              pass_cnt_d = pass_cnt_q + 1'b1;
              step_d     = '0;
              state_d    = StApply;
            end
          end else begin
            step_d  = step_q + 1'b1;
            state_d = StApply;
          end
        end
        StFinish: state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end

    if (state_d == StFinish) begin
      done_d = 1'b1;
      pass_d = !aborted && (err_d == '0);
    end

    // Vector register is loaded on entry to APPLY so the drive is registered.
    if (state_d == StApply) begin
      vec_d = gray4(step_d);
    end else if ((state_d == StIdle) || (state_d == StFinish)) begin
      vec_d = '0;
    end else begin
      vec_d = vec_q;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (!rn_i) begin
      state_q    <= StIdle;
      step_q     <= '0;
      pass_cnt_q <= '0;
      vec_q      <= '0;
      err_q      <= '0;
      fail_q     <= '0;
      pass_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      pass_cnt_q <= pass_cnt_d;
      vec_q      <= vec_d;
      err_q      <= err_d;
      fail_q     <= fail_d;
      pass_q     <= pass_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign a1_o       = vec_q[3];
  assign a2_o       = vec_q[2];
  assign b_o        = vec_q[1];
  assign c_o        = vec_q[0];
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign pass_o     = pass_q;
  assign err_cnt_o  = err_q;
  assign fail_vec_o = fail_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__oai211_bist.sv
// Bench: three sequencer configurations share stimulus, each checked cycle-by-cycle against a run model.
module tb_gf180mcu_fd_sc_mcu7t5v0__oai211_bist;

  logic        clk_i   = 1'b0;
  logic        rn_i    = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  bit          chk_en  = 1'b0;
  int          fault_mode = 0;  // 0 good, 1 stuck-at-1, 2 stuck-at-0, 3 flip vectors in mask
  logic [15:0] fault_mask = '0;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk_i = ~clk_i;

  function automatic logic [3:0] gray(input int i);
    logic [3:0] b;
    b = 4'(i % 16);
    return b ^ (b >> 1);
  endfunction

  function automatic bit exp_zn(input logic [3:0] v);
    return !((v[3] | v[2]) & v[1] & v[0]);
  endfunction

  function automatic bit mism(input int mode, input logic [15:0] mask, input logic [3:0] v);
    case (mode)
      0:       return 1'b0;
      1:       return exp_zn(v) != 1'b1;
      2:       return exp_zn(v) != 1'b0;
      default: return mask[v];
    endcase
  endfunction

  task automatic chk(input string name, input int inst, input logic [31:0] got,
                     input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0h, want %0h", name, inst, got, want);
    end
  endtask

  // Error count and first failing vector after the first c vectors of a run.
  task automatic err_model(input int c, input int mode, input logic [15:0] mask,
                           output logic [4:0] e, output logic [3:0] f);
    int n;
    n = 0;
    f = '0;
    for (int i = 0; i < c; i++) begin
      if (mism(mode, mask, gray(i))) begin
        if (n == 0) f = gray(i);
        n++;
      end
    end
    e = (n > 31) ? 5'd31 : 5'(n);
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int unsigned S = (g == 0) ? 2 : 1;
    localparam int unsigned P = (g == 1) ? 4 : 1;

    logic       a1, a2, b, c, zn, busy, done, pass;
    logic [4:0] err;
    logic [3:0] fvec, vec;

    assign vec = {a1, a2, b, c};
    assign zn  = (fault_mode == 1) ? 1'b1 :
                 (fault_mode == 2) ? 1'b0 :
                 (exp_zn(vec) ^ ((fault_mode == 3) && fault_mask[vec]));

    gf180mcu_fd_sc_mcu7t5v0__oai211_bist #(
      .SETTLE_CYCLES(S),
      .PASSES       (P)
    ) u_dut (
      .clk_i     (clk_i),
      .rn_i      (rn_i),
      .start_i   (start_i),
      .abort_i   (abort_i),
      .zn_i      (zn),
      .a1_o      (a1),
      .a2_o      (a2),
      .b_o       (b),
      .c_o       (c),
      .busy_o    (busy),
      .done_o    (done),
      .pass_o    (pass),
      .err_cnt_o (err),
      .fail_vec_o(fvec)
    );

    // Run model: m_k counts cycles since the edge that took START (1 = first cycle).
    bit          m_run  = 1'b0;
    int          m_k    = 0;
    int          m_ak   = 0;
    int          m_mode = 0;
    logic [15:0] m_mask = '0;
    logic [4:0]  m_err  = '0;
    logic [3:0]  m_fail = '0;
    bit          m_pass = 1'b0;

    always @(negedge clk_i) begin : p_model
      int         per, total, end_k, cnt;
      logic [4:0] e_err;
      logic [3:0] e_fail, e_vec;
      bit         e_busy, e_done, e_pass;
      per    = S + 2;
      total  = P * 16 * per;
      end_k  = (m_ak != 0) ? m_ak + 1 : total + 1;
      e_busy = 1'b0;
      e_done = 1'b0;
      e_vec  = '0;
      e_err  = m_err;
      e_fail = m_fail;
      e_pass = m_pass;
      if (m_run) begin
        e_busy = 1'b1;
        e_pass = 1'b0;
        if (m_k < end_k) begin
          cnt   = (m_k - 1) / per;
          e_vec = gray(cnt);
        end else begin
          cnt    = (m_ak != 0) ? (m_ak - 1) / per : P * 16;
          e_done = 1'b1;
        end
        err_model(cnt, m_mode, m_mask, e_err, e_fail);
        if (e_done) e_pass = (m_ak == 0) && (e_err == 5'd0);
      end
      if (chk_en) begin
        chk("busy", g, busy, e_busy);
        chk("done", g, done, e_done);
        chk("pass", g, pass, e_pass);
        chk("vec", g, vec, e_vec);
        chk("err_cnt", g, err, e_err);
        chk("fail_vec", g, fvec, e_fail);
      end
      if (!rn_i) begin
        m_run  = 1'b0;
        m_err  = '0;
        m_fail = '0;
        m_pass = 1'b0;
      end else if (m_run) begin
        if (m_k == end_k) begin
          m_run  = 1'b0;
          m_err  = e_err;
          m_fail = e_fail;
          m_pass = e_pass;
        end else begin
          if (abort_i && (m_ak == 0)) m_ak = m_k;
          m_k++;
        end
      end else if (start_i) begin
        m_run  = 1'b1;
        m_k    = 1;
        m_ak   = 0;
        m_mode = fault_mode;
        m_mask = fault_mask;
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  task automatic start_run();
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((g_inst[0].busy || g_inst[1].busy || g_inst[2].busy) && (n < limit)) begin
      cyc();
      n++;
    end
    chk("idle_timeout", 0, 32'(n < limit), 1);
  endtask

  initial begin
    int kk, d0, d1, d2, ak, sk;

    rn_i = 1'b0;
    repeat (2) cyc();
    chk_en = 1'b1;
    cyc();
    chk("rst_busy", 0, g_inst[0].busy, 0);
    chk("rst_err", 0, g_inst[0].err, 0);
    chk("rst_vec", 0, g_inst[0].vec, 0);
    rn_i = 1'b1;
    cyc();

    // Good cell; a second START mid-run must be ignored.
    fault_mode = 0;
    start_run();
    chk("start_busy", 0, g_inst[0].busy, 1);
    chk("first_vec", 0, g_inst[0].vec, 4'b0000);
    kk = 1; d0 = 0; d1 = 0; d2 = 0;
    while (((d0 == 0) || (d1 == 0) || (d2 == 0)) && (kk < 400)) begin
      if (kk == 9) chk("gray_step2", 0, g_inst[0].vec, 4'b0011);
      if (kk == 13) chk("gray_step3", 0, g_inst[0].vec, 4'b0010);
      if (g_inst[0].done && (d0 == 0)) d0 = kk;
      if (g_inst[1].done && (d1 == 0)) d1 = kk;
      if (g_inst[2].done && (d2 == 0)) d2 = kk;
      start_i = (kk == 10);
      cyc();
      kk++;
    end
    start_i = 1'b0;
    chk("done_cycle", 0, d0, 65);
    chk("done_cycle", 1, d1, 193);
    chk("done_cycle", 2, d2, 49);
    wait_idle(20);
    chk("pass_good", 0, g_inst[0].pass, 1);
    chk("pass_good", 2, g_inst[2].pass, 1);

    // Stuck-at-1; ABORT alone in IDLE is ignored, START+ABORT starts a run.
    fault_mode = 1;
    abort_i = 1'b1;
    cyc();
    chk("abort_idle", 0, g_inst[0].busy, 0);
    start_run();
    abort_i = 1'b0;
    chk("start_wins", 0, g_inst[0].busy, 1);
    wait_idle(300);
    chk("sa1_err", 0, g_inst[0].err, 3);
    chk("sa1_fvec", 0, g_inst[0].fvec, 4'b0111);
    chk("sa1_pass", 0, g_inst[0].pass, 0);
    chk("sa1_err", 1, g_inst[1].err, 12);

    // Stuck-at-0; four passes saturate the counter.
    fault_mode = 2;
    start_run();
    wait_idle(300);
    chk("sa0_err", 1, g_inst[1].err, 31);
    chk("sa0_fvec", 1, g_inst[1].fvec, 4'b0000);
    chk("sa0_pass", 1, g_inst[1].pass, 0);
    chk("sa0_err", 0, g_inst[0].err, 13);

    // Abort during SETTLE of step 3 (defaults): three completed checks all miss.
    start_run();
    repeat (13) cyc();
    abort_i = 1'b1;
    cyc();
    abort_i = 1'b0;
    chk("abort_done", 0, g_inst[0].done, 1);
    chk("abort_pass", 0, g_inst[0].pass, 0);
    chk("abort_err", 0, g_inst[0].err, 3);
    cyc();
    chk("abort_busy", 0, g_inst[0].busy, 0);
    chk("abort_vec", 0, g_inst[0].vec, 0);
    wait_idle(20);

    // Reset at step 8, then a clean run.
    fault_mode = 0;
    start_run();
    repeat (32) cyc();
    rn_i = 1'b0;
    cyc();
    rn_i = 1'b1;
    chk("mid_rst_busy", 0, g_inst[0].busy, 0);
    chk("mid_rst_vec", 0, g_inst[0].vec, 0);
    chk("mid_rst_done", 0, g_inst[0].done, 0);
    chk("mid_rst_err", 1, g_inst[1].err, 0);
    start_run();
    wait_idle(300);
    chk("post_rst_pass", 0, g_inst[0].pass, 1);

    // Randomized runs: fault pattern, optional abort, stray START.
    for (int r = 0; r < 8; r++) begin
      fault_mode = int'($urandom_range(0, 3));
      fault_mask = 16'($urandom);
      ak = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 40)) : 0;
      sk = int'($urandom_range(2, 30));
      start_run();
      kk = 1;
      while ((g_inst[0].busy || g_inst[1].busy || g_inst[2].busy) && (kk < 600)) begin
        abort_i = (kk == ak);
        start_i = (kk == sk);
        cyc();
        kk++;
      end
      abort_i = 1'b0;
      start_i = 1'b0;
      wait_idle(20);
    end

    repeat (2) cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
